// File: rtl/aes_pkg.sv
// Shared AES SubBytes definitions: forward/inverse S-box tables, engine state type and lookup helper.
// The inverse table exists only when INV_SBOX_EN is defined; otherwise lookups are always forward.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} sbe_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

`ifdef INV_SBOX_EN
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };
`endif

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b, input logic inv);
`ifdef INV_SBOX_EN
        return inv ? INV_SBOX[b] : SBOX[b];
`else
        // Forward-only build: the mode bit has no table to select.
        return SBOX[b];
`endif
    endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lookup lane; the engine instantiates LANES of these.
module aes_sbox_lane
    import aes_pkg::*;
(
    input  logic [7:0] data_in,
    input  logic       inv,
    output logic [7:0] data_out
);

    assign data_out = sbox_lookup(data_in, inv);

endmodule

// File: rtl/sub_bytes_engine.sv
// Multi-cycle AES SubBytes engine: LANES bytes substituted in place per beat, result held until taken.
// Define INV_SBOX_EN to enable per-word inverse substitution selected by in_inv.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int NUM_BYTES = 16,
    parameter int LANES     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] in_data,
    input  logic                   in_inv,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] out_data,
    output logic                   busy
);

    localparam int DATA_W    = 8 * NUM_BYTES;
    localparam int NUM_BEATS = NUM_BYTES / LANES;
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    if (NUM_BYTES % LANES != 0) begin : g_bad_cfg
        $error("sub_bytes_engine: NUM_BYTES must be a multiple of LANES");
    end

    sbe_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] buf_reg, buf_next;
    logic              inv_reg, inv_next;
    logic [7:0]        lane_out [LANES];

    // Each lane reads the byte of the current beat straight out of the buffer.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        aes_sbox_lane u_lane (
            .data_in  (buf_reg[8*(LANES*int'(cnt_reg) + gi) +: 8]),
            .inv      (inv_reg),
            .data_out (lane_out[gi])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            buf_reg   <= '0;
            inv_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            buf_reg   <= buf_next;
            inv_reg   <= inv_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        buf_next   = buf_reg;
        inv_next   = inv_reg;
        if (flush) begin
            // Abort leaves the buffer untouched; the output mask hides it.
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        buf_next   = in_data;
                        inv_next   = in_inv;
                        cnt_next   = '0;
                        state_next = BUSY;
                    end
                end
                BUSY: begin
                    for (int i = 0; i < LANES; i++) begin
                        buf_next[8*(LANES*int'(cnt_reg) + i) +: 8] = lane_out[i];
                    end
                    if (cnt_reg == CNT_W'(NUM_BEATS - 1)) begin
                        cnt_next   = '0;
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign out_data  = (state_reg == DONE) ? buf_reg : '0;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine: three instances (LANES 1, 4, 16) with a queue-based scoreboard.
module tb_sub_bytes_engine;

    localparam int NI = 3;
    localparam int LANE_CFG [NI] = '{1, 4, 16};
    localparam int LAT      [NI] = '{17, 5, 2};

    localparam logic [127:0] T1_IN   = 128'h0000_0000_0000_0000_0000_0000_0000_5300;
    localparam logic [127:0] T1_OUT  = 128'h6363_6363_6363_6363_6363_6363_6363_ed63;
    localparam logic [127:0] T2_IN   = 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19;
    localparam logic [127:0] T2_OUT  = 128'h3052411e_e55db4b8_f198bfe0_ae1127d4;
    localparam logic [127:0] T2_FWD2 = 128'h04008372_d94c8d6c_a14608e1_e482cc48;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] in_data = '0;
    logic         in_inv = 1'b0;
    logic         flush = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_valid  [NI] = '{1'b0, 1'b0, 1'b0};
    logic         in_ready  [NI];
    logic         out_valid [NI];
    logic         busy      [NI];
    logic [127:0] out_data  [NI];

    int checks = 0;
    int failures = 0;
    logic [127:0] sb_q [$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        sub_bytes_engine #(.NUM_BYTES(16), .LANES(LANE_CFG[gi])) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .in_data   (in_data),
            .in_inv    (in_inv),
            .flush     (flush),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready),
            .out_data  (out_data[gi]),
            .busy      (busy[gi])
        );
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input int idx, input string tag);
        chk({tag, "_in_ready"}, 128'(in_ready[idx]), 128'd1);
        chk({tag, "_busy"}, 128'(busy[idx]), 128'd0);
        chk({tag, "_out_valid"}, 128'(out_valid[idx]), 128'd0);
        chk({tag, "_out_data"}, out_data[idx], 128'd0);
    endtask

    // Drive one word, count edges until out_valid, then check latency and data from the scoreboard.
    task automatic send(input int idx, input logic [127:0] d, input logic inv,
                        input logic [127:0] exp, input string tag);
        int edges;
        logic [127:0] want;
        sb_q.push_back(exp);
        chk({tag, "_ready_before"}, 128'(in_ready[idx]), 128'd1);
        in_data = d;
        in_inv = inv;
        in_valid[idx] = 1'b1;
        edges = 0;
        do begin
            tick();
            edges++;
            if (edges == 1) begin
                in_valid[idx] = 1'b0;
                in_inv = ~inv;
                in_data = ~d;
            end
        end while (!out_valid[idx] && edges < 200);
        chk({tag, "_latency"}, 128'(edges), 128'(LAT[idx]));
        if (sb_q.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 128'd1, 128'd0);
        end else begin
            want = sb_q.pop_front();
            chk({tag, "_data"}, out_data[idx], want);
        end
        chk({tag, "_busy_done"}, 128'(busy[idx]), 128'd1);
        $display("txn %s lanes=%0d edges=%0d in=%h out=%h", tag, LANE_CFG[idx], edges, d, out_data[idx]);
    endtask

    task automatic take(input int idx, input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_idle(idx, {tag, "_after_take"});
    endtask

    initial begin
        tick();
        tick();
        for (int i = 0; i < NI; i++) chk_idle(i, "reset");
        rst = 1'b0;
        tick();

        // 1: single forward byte checks
        send(1, T1_IN, 1'b0, T1_OUT, "t1_fwd_bytes");
        take(1, "t1");

        // 2: FIPS-197 forward vector
        send(1, T2_IN, 1'b0, T2_OUT, "t2_fips_fwd");
        take(1, "t2");

        // 3: inverse mode recovers the input, or forward result in a forward-only build
`ifdef INV_SBOX_EN
        send(1, T2_OUT, 1'b1, T2_IN, "t3_inverse");
`else
        send(1, T2_OUT, 1'b1, T2_FWD2, "t3_inv_ignored");
`endif
        take(1, "t3");

        // 4: backpressure in DONE with a competing input word
        send(1, T1_IN, 1'b0, T1_OUT, "t4_backpressure");
        in_data = T2_IN;
        in_valid[1] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("t4_hold_data", out_data[1], T1_OUT);
            chk("t4_hold_valid", 128'(out_valid[1]), 128'd1);
            chk("t4_hold_in_ready", 128'(in_ready[1]), 128'd0);
        end
        in_valid[1] = 1'b0;
        take(1, "t4");

        // 5a: flush at beat 2 of BUSY
        in_data = T2_IN;
        in_valid[1] = 1'b1;
        tick();
        in_valid[1] = 1'b0;
        tick();
        tick();
        chk("t5_busy_before_flush", 128'(busy[1]), 128'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_idle(1, "t5_after_flush");
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("t5_no_out_valid", 128'(out_valid[1]), 128'd0);
        end

        // 5b: flush coincident with in_valid in IDLE
        in_data = T2_IN;
        in_valid[1] = 1'b1;
        flush = 1'b1;
        tick();
        in_valid[1] = 1'b0;
        flush = 1'b0;
        chk_idle(1, "t5_flush_vs_valid");
        tick();
        chk_idle(1, "t5_no_capture");
        send(1, T2_IN, 1'b0, T2_OUT, "t5_after_flush_word");

        // 5c: flush with out_ready in DONE discards the result
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        chk_idle(1, "t5_flush_done");

        // 6: lane sweep and reset mid-BUSY
        send(0, T2_IN, 1'b0, T2_OUT, "t6_lanes1");
        take(0, "t6_l1");
        send(2, T2_IN, 1'b0, T2_OUT, "t6_lanes16");
        take(2, "t6_l16");

        in_data = T2_IN;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        tick();
        chk("t6_busy_before_rst", 128'(busy[0]), 128'd1);
        rst = 1'b1;
        #1;
        chk_idle(0, "t6_async_rst");
        tick();
        rst = 1'b0;
        tick();
        chk_idle(0, "t6_after_rst");
        send(0, T1_IN, 1'b0, T1_OUT, "t6_recover");
        take(0, "t6_rec");

        chk("scoreboard_drained", 128'(sb_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
